// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bus type and the hex glyph table, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment glyph decoder (logical 1 = segment lit).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with refresh divider, inter-digit blanking,
// selectable polarity and a one-entry load buffer applied only at frame boundaries.
module seven_seg_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 16,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   en_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [N_DIGITS-1:0]   anode,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W = NIB_W * N_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                slotWrap;
    logic                frameEnd;
    logic                accept;

    logic [VAL_W-1:0]    valPend;
    logic [N_DIGITS-1:0] dpPend;
    logic [N_DIGITS-1:0] enPend;
    logic [VAL_W-1:0]    valSh;
    logic [N_DIGITS-1:0] dpSh;
    logic [N_DIGITS-1:0] enSh;

    logic [NIB_W-1:0]    curNib;
    logic [SEG_W-1:0]    curSeg;
    logic [N_DIGITS-1:0] anodeNext;
    logic [SEG_W-1:0]    segNext;
    logic                dpNext;

    assign slotWrap = (cnt == CNT_LAST);
    assign frameEnd = slotWrap && (idx == IDX_LAST);
    assign accept   = load_valid && load_ready;

    // Refresh divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotWrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One-entry pending buffer; load_ready doubles as its empty flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valPend    <= '0;
            dpPend     <= '0;
            enPend     <= '0;
            valSh      <= '0;
            dpSh       <= '0;
            enSh       <= '0;
            load_ready <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frameEnd;
            if (frameEnd && !load_ready) begin
                valSh      <= valPend;
                dpSh       <= dpPend;
                enSh       <= enPend;
                load_ready <= 1'b1;
            end else if (accept) begin
                valPend    <= value_in;
                dpPend     <= dp_in;
                enPend     <= en_in;
                load_ready <= 1'b0;
            end
        end
    end

    assign curNib = valSh[{idx, 2'b00} +: NIB_W];

    hex_to_seg7 u_dec (
        .nibble (curNib),
        .seg    (curSeg)
    );

    // Logical (active-high) display state for the current cnt/idx
    always_comb begin
        anodeNext = '0;
        segNext   = SEG_BLANK;
        dpNext    = 1'b0;
        if (cnt >= BLANK_END) begin
            segNext = curSeg;
            dpNext  = dpSh[idx] & enSh[idx];
            if (enSh[idx]) begin
                anodeNext[idx] = 1'b1;
            end
        end
    end

    // Polarity stage, registered toward the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode <= {N_DIGITS{ACTIVE_LOW}};
            seg   <= {SEG_W{ACTIVE_LOW}};
            dp    <= ACTIVE_LOW;
        end else begin
            anode <= anodeNext ^ {N_DIGITS{ACTIVE_LOW}};
            seg   <= segNext ^ {SEG_W{ACTIVE_LOW}};
            dp    <= dpNext ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: active-high and active-low instances share stimulus;
// accepted loads queue as expected shadow contents and are popped at each frame boundary.
module tb_seven_seg_scan_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned TD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned FRAME = TD * ND;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
    } load_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load_valid;

    logic        readyA, dpA, fdA;
    logic [3:0]  anodeA;
    logic [6:0]  segA;
    logic        readyL, dpL, fdL;
    logic [3:0]  anodeL;
    logic [6:0]  segL;

    int          t;
    logic [15:0] mVal;
    logic [3:0]  mDp;
    logic [3:0]  mEn;
    load_t       pendQ[$];
    int          nChecks;
    int          nPass;

    seven_seg_scan_ctrl #(.N_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b0)) dutHi (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .en_in(en_in),
        .load_valid(load_valid), .load_ready(readyA), .anode(anodeA), .seg(segA),
        .dp(dpA), .frame_done(fdA)
    );

    seven_seg_scan_ctrl #(.N_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dutLo (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .en_in(en_in),
        .load_valid(load_valid), .load_ready(readyL), .anode(anodeL), .seg(segL),
        .dp(dpL), .frame_done(fdL)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segRef(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        assert (got === exp) nPass++;
        else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
    endtask

    task automatic checkOutputs(input logic [3:0] aE, input logic [6:0] sE, input logic dE,
                                input logic fE, input logic rE);
        logic [3:0] aInv;
        logic [6:0] sInv;
        logic       dInv;
        aInv = ~aE;
        sInv = ~sE;
        dInv = ~dE;
        chk("anode",      {28'd0, anodeA}, {28'd0, aE});
        chk("seg",        {25'd0, segA},   {25'd0, sE});
        chk("dp",         {31'd0, dpA},    {31'd0, dE});
        chk("frame_done", {31'd0, fdA},    {31'd0, fE});
        chk("load_ready", {31'd0, readyA}, {31'd0, rE});
        chk("anode_al",   {28'd0, anodeL}, {28'd0, aInv});
        chk("seg_al",     {25'd0, segL},   {25'd0, sInv});
        chk("dp_al",      {31'd0, dpL},    {31'd0, dInv});
        chk("frame_done_al", {31'd0, fdL},    {31'd0, fE});
        chk("load_ready_al", {31'd0, readyL}, {31'd0, rE});
    endtask

    // One clock: predict outputs from pre-edge model state, then advance the model
    task automatic step();
        int         c;
        int         i;
        logic       bnd;
        logic       acc;
        logic [3:0] aE;
        logic [6:0] sE;
        logic       dE;
        c   = t % TD;
        i   = (t / TD) % ND;
        bnd = ((t % FRAME) == FRAME - 1);
        acc = load_valid && (pendQ.size() == 0);
        aE  = 4'd0;
        sE  = 7'd0;
        dE  = 1'b0;
        if (c >= BC) begin
            sE = segRef(mVal[4*i +: 4]);
            dE = mDp[i] & mEn[i];
            if (mEn[i]) aE = 4'(1 << i);
        end
        @(posedge clk);
        #1;
        if (bnd && pendQ.size() != 0) begin
            load_t ld;
            ld   = pendQ.pop_front();
            mVal = ld.val;
            mDp  = ld.dp;
            mEn  = ld.en;
        end else if (acc) begin
            pendQ.push_back('{val: value_in, dp: dp_in, en: en_in});
        end
        checkOutputs(aE, sE, dE, bnd, pendQ.size() == 0);
        t++;
    endtask

    // Assert reset away from any clock edge, check immediate effect, release at a negedge
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutputs(4'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        t    = 0;
        mVal = '0;
        mDp  = '0;
        mEn  = '0;
        pendQ.delete();
    endtask

    task automatic loadOnce(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value_in   = v;
        dp_in      = d;
        en_in      = e;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        value_in   = '0;
        dp_in      = '0;
        en_in      = '0;
        load_valid = 1'b0;
        nChecks    = 0;
        nPass      = 0;
        t          = 0;
        #2;
        doReset();

        // All digits enabled, value 0: basic scan and frame_done cadence
        loadOnce(16'h0000, 4'h0, 4'hF);
        repeat (2 * FRAME) step();

        // Mid-frame load: held off until the boundary
        repeat (10) step();
        loadOnce(16'h1234, 4'h0, 4'hF);
        repeat (2 * FRAME) step();

        // Second load held valid while the first is pending
        loadOnce(16'hABCD, 4'h0, 4'hF);
        value_in   = 16'h8765;
        dp_in      = 4'b1010;
        load_valid = 1'b1;
        repeat (FRAME + 4) step();
        load_valid = 1'b0;
        repeat (2 * FRAME) step();

        // Partial enable, single dp, digit 0 = 8 (active-low instance shows all segments low)
        loadOnce(16'h9F08, 4'b0001, 4'b0101);
        repeat (2 * FRAME) step();

        // Mid-slot reset with a pending load: the load must be lost
        while ((t % FRAME) != 5) step();
        loadOnce(16'hFFFF, 4'hF, 4'hF);
        repeat (3) step();
        #2;
        doReset();
        repeat (2 * FRAME + 4) step();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
